vga_timing_gen: RTL and testbench

//   Raster timing generator clocked by the 40 MHz VGA PLL output clock.

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator: syncs, data enable,
// pixel coordinates and the line/frame start strobes.
interface vga_timing_gen_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           line_start;
  logic           frame_start;

  // Timing generator side
  modport master (
    output hsync,
    output vsync,
    output de,
    output x,
    output y,
    output line_start,
    output frame_start
  );

  // Pixel pipeline / DAC side
  modport slave (
    input hsync,
    input vsync,
    input de,
    input x,
    input y,
    input line_start,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator (800x600@60 Hz defaults) running on the PLL pixel
// clock. Timing is held at the origin until the PLL lock flag has passed
// through a 2-flop synchroniser; all raster outputs are registered copies
// decoded from the horizontal/vertical counters, one clock behind them.
module vga_timing_gen #(
  parameter int H_ACT  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_ACT  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int X_W    = 11,
  parameter int Y_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  vga_timing_gen_if.master     vga
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  // Counter-width versions of the timing boundaries
  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_C  = X_W'(H_ACT);
  localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACT + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_C  = Y_W'(V_ACT);
  localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACT + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACT + V_FP + V_SYNC);

  // Lock synchroniser
  logic lock_meta_q, lock_meta_d;
  logic run_q, run_d;

  // Raster counters
  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;

  // Window decode of the current counter values
  logic h_act_win, h_sync_win, h_zero;
  logic v_act_win, v_sync_win, v_zero;

  // Registered outputs
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;

  // Two-stage capture of the asynchronous lock flag; run is the second stage
  always_comb begin
    lock_meta_d = pll_locked;
    run_d       = lock_meta_q;
  end

  // Synchroniser flops, cleared by reset so relock always takes 2 clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      run_q       <= run_d;
    end
  end

  // Counter next-state: hold at the origin without lock, otherwise raster scan
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_q) begin
      // Losing lock discards the partial line/frame; relock starts at (0,0)
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + Y_W'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + X_W'(1);
    end
  end

  // Counter flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Window decode of the counters (feeds the output registers only)
  always_comb begin
    h_act_win  = (h_cnt_q < H_ACT_C);
    h_sync_win = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    h_zero     = (h_cnt_q == '0);
    v_act_win  = (v_cnt_q < V_ACT_C);
    // v only moves on the h wrap, so vsync edges line up with x==0
    v_sync_win = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    v_zero     = (v_cnt_q == '0);
  end

  // Output next-state: inactive levels unless timing is running
  always_comb begin
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (run_q) begin
      hsync_d       = h_sync_win ? HS_POL : ~HS_POL;
      vsync_d       = v_sync_win ? VS_POL : ~VS_POL;
      de_d          = h_act_win && v_act_win;
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      line_start_d  = h_zero;
      frame_start_d = h_zero && v_zero;
    end
  end

  // Output registers; nothing reaches the pins combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 800x600 instance plus a tiny-geometry
// instance (whole frames fit in a short run), both checked every cycle
// against a raster model driven by the lock history.
module tb_vga_timing_gen;

  // Tiny geometry: 32 clocks per line, 14 lines per frame, negative hsync
  localparam int SH_ACT = 20, SH_FP = 3, SH_SYNC = 5, SH_BP = 4;
  localparam int SV_ACT = 8,  SV_FP = 1, SV_SYNC = 2, SV_BP = 3;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;

  vga_timing_gen_if #(.X_W(11), .Y_W(10)) vm ();
  vga_timing_gen_if #(.X_W(6),  .Y_W(4))  vs ();

  vga_timing_gen #(.X_W(11), .Y_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .vga        (vm)
  );

  vga_timing_gen #(
    .H_ACT(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACT(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .HS_POL(1'b0), .VS_POL(1'b1), .X_W(6), .Y_W(4)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .vga        (vs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Model: outputs are active once the lock flag sampled two edges earlier
  // is high; streak counts consecutive such edges, i.e. position in raster.
  bit lock_hist[$];
  int streak = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        lock_hist.delete();
        streak = 0;
      end else begin
        lock_hist.push_back(pll_locked);
        if (lock_hist.size() > 3) void'(lock_hist.pop_front());
        if (lock_hist.size() == 3 && lock_hist[0]) streak++;
        else streak = 0;
      end
    end
  end

  function automatic void model_out(
    input int s, input int ha, input int hf, input int hw, input int hb,
    input int va, input int vf, input int vw, input int vb,
    input bit hp, input bit vp,
    output logic hs_e, output logic vs_e, output logic de_e,
    output logic ls_e, output logic fs_e, output int x_e, output int y_e);
    longint p;
    int ht, vt;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (s == 0) begin
      hs_e = ~hp; vs_e = ~vp; de_e = 1'b0; ls_e = 1'b0; fs_e = 1'b0;
      x_e = 0; y_e = 0;
    end else begin
      p    = longint'(s) - 1;
      x_e  = int'(p % ht);
      y_e  = int'((p / ht) % vt);
      de_e = (x_e < ha) && (y_e < va);
      hs_e = (x_e >= ha + hf && x_e < ha + hf + hw) ? hp : ~hp;
      vs_e = (y_e >= va + vf && y_e < va + vf + vw) ? vp : ~vp;
      ls_e = (x_e == 0);
      fs_e = (x_e == 0) && (y_e == 0);
    end
  endfunction

  // Per-cycle compare of both instances against the model
  initial begin
    logic hs_e, vs_e, de_e, ls_e, fs_e;
    int x_e, y_e;
    forever begin
      @(posedge clk);
      #2;
      model_out(streak, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1,
                hs_e, vs_e, de_e, ls_e, fs_e, x_e, y_e);
      check("m_hsync", 64'(vm.hsync), 64'(hs_e));
      check("m_vsync", 64'(vm.vsync), 64'(vs_e));
      check("m_de",    64'(vm.de),    64'(de_e));
      check("m_x",     64'(vm.x),     64'(x_e));
      check("m_y",     64'(vm.y),     64'(y_e));
      check("m_ls",    64'(vm.line_start),  64'(ls_e));
      check("m_fs",    64'(vm.frame_start), 64'(fs_e));
      model_out(streak, SH_ACT, SH_FP, SH_SYNC, SH_BP, SV_ACT, SV_FP, SV_SYNC, SV_BP,
                1'b0, 1'b1, hs_e, vs_e, de_e, ls_e, fs_e, x_e, y_e);
      check("s_hsync", 64'(vs.hsync), 64'(hs_e));
      check("s_vsync", 64'(vs.vsync), 64'(vs_e));
      check("s_de",    64'(vs.de),    64'(de_e));
      check("s_x",     64'(vs.x),     64'(x_e));
      check("s_y",     64'(vs.y),     64'(y_e));
      check("s_ls",    64'(vs.line_start),  64'(ls_e));
      check("s_fs",    64'(vs.frame_start), 64'(fs_e));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, de_n, hs_n, ls_n, vs_n, hs_first, hs_last, vs_fx, vs_fy, px, py, mode;

    // Reset, then idle without lock
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (100) tick();
    check("idle_x", 64'(vm.x), 0);
    check("idle_de", 64'(vm.de), 0);
    check("idle_hsync", 64'(vm.hsync), 0);
    check("idle_vsync", 64'(vm.vsync), 0);
    check("idle_fs", 64'(vm.frame_start), 0);
    check("idle_s_hsync", 64'(vs.hsync), 1);

    // Lock: first frame_start on the 3rd edge after the rise
    @(negedge clk) pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!vm.frame_start && n < 20);
    check("lock_latency", 64'(n), 3);
    check("first_x", 64'(vm.x), 0);
    check("first_y", 64'(vm.y), 0);
    check("first_de", 64'(vm.de), 1);
    check("first_ls", 64'(vm.line_start), 1);

    // One full line of the 800x600 instance
    de_n = 0; hs_n = 0; ls_n = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 1056; i++) begin
      if (vm.de) de_n++;
      if (vm.line_start) ls_n++;
      if (vm.hsync) begin
        if (hs_first < 0) hs_first = int'(vm.x);
        hs_last = int'(vm.x);
        hs_n++;
      end
      tick();
    end
    check("line_de_clocks", 64'(de_n), 800);
    check("line_hs_clocks", 64'(hs_n), 128);
    check("line_hs_first_x", 64'(hs_first), 840);
    check("line_hs_last_x", 64'(hs_last), 967);
    check("line_ls_count", 64'(ls_n), 1);
    check("line2_ls", 64'(vm.line_start), 1);
    check("line2_x", 64'(vm.x), 0);
    check("line2_y", 64'(vm.y), 1);

    // One full frame of the tiny instance
    n = 0;
    while (!vs.frame_start && n < 1000) begin tick(); n++; end
    check("s_fs_found", 64'(vs.frame_start), 1);
    n = 0; vs_n = 0; de_n = 0; vs_fx = -1; vs_fy = -1; px = -1; py = -1;
    do begin
      if (vs.de) de_n++;
      if (vs.vsync) begin
        if (vs_fx < 0) begin vs_fx = int'(vs.x); vs_fy = int'(vs.y); end
        vs_n++;
      end
      px = int'(vs.x);
      py = int'(vs.y);
      tick();
      n++;
    end while (!vs.frame_start && n < 1000);
    check("s_frame_period", 64'(n), 448);
    check("s_vs_clocks", 64'(vs_n), 64);
    check("s_de_clocks", 64'(de_n), 160);
    check("s_vs_first_x", 64'(vs_fx), 0);
    check("s_vs_first_y", 64'(vs_fy), 9);
    check("s_wrap_x", 64'(px), 31);
    check("s_wrap_y", 64'(py), 13);

    // Drop lock mid-frame, hold off 10 clocks, relock
    n = 0;
    while (!(vm.y == 20 && vm.x == 400) && n < 30000) begin tick(); n++; end
    check("drop_point_y", 64'(vm.y), 20);
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(vm.de == 1'b0 && vm.x == 0 && vm.y == 0) && n < 10);
    check("drop_latency", 64'(n), 3);
    check("drop_hsync", 64'(vm.hsync), 0);
    check("drop_ls", 64'(vm.line_start), 0);
    repeat (7) tick();
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!vm.de && !vm.frame_start && n < 10);
    check("relock_latency", 64'(n), 3);
    check("relock_fs_first", 64'(vm.frame_start), 1);
    check("relock_x", 64'(vm.x), 0);

    // Asynchronous reset between edges
    repeat (50) tick();
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("arst_de", 64'(vm.de), 0);
    check("arst_x", 64'(vm.x), 0);
    check("arst_y", 64'(vm.y), 0);
    check("arst_hsync", 64'(vm.hsync), 0);
    check("arst_ls", 64'(vm.line_start), 0);
    check("arst_s_hsync", 64'(vs.hsync), 1);
    check("arst_s_x", 64'(vs.x), 0);
    @(negedge clk) rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!vm.frame_start && n < 20);
    check("arst_relock_latency", 64'(n), 3);

    // Randomised lock activity, glitches and reset pulses
    for (int seg = 0; seg < 60; seg++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 6) begin
        @(negedge clk) pll_locked = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 700)) @(negedge clk);
      end else if (mode < 9) begin
        @(negedge clk) pll_locked = ~pll_locked;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        pll_locked = ~pll_locked;
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end else begin
        @(posedge clk);
        #($urandom_range(3, 8));
        rst = 1'b1;
        #($urandom_range(1, 25));
        @(negedge clk) rst = 1'b0;
      end
    end

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
